// File: rtl/fmul_issue_if.sv
// Handshake bundle for fmul_issue: request, fmul operand/result and writeback.
// The flush signal exists only when FMUL_ISSUE_FLUSH_EN is defined.
interface fmul_issue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x1;
    logic [31:0]      req_x2;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      mul_x1;
    logic [31:0]      mul_x2;
    logic [31:0]      mul_y;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_y;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
`ifdef FMUL_ISSUE_FLUSH_EN
    logic             flush;

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag,
        input  mul_y, res_ready, flush,
        output req_ready, mul_x1, mul_x2,
        output res_valid, res_y, res_tag, busy
    );

    modport master (
        output req_valid, req_x1, req_x2, req_tag,
        output mul_y, res_ready, flush,
        input  req_ready, mul_x1, mul_x2,
        input  res_valid, res_y, res_tag, busy
    );
`else
    modport slave (
        input  req_valid, req_x1, req_x2, req_tag,
        input  mul_y, res_ready,
        output req_ready, mul_x1, mul_x2,
        output res_valid, res_y, res_tag, busy
    );

    modport master (
        output req_valid, req_x1, req_x2, req_tag,
        output mul_y, res_ready,
        input  req_ready, mul_x1, mul_x2,
        input  res_valid, res_y, res_tag, busy
    );
`endif
endinterface

// File: rtl/fmul_issue.sv
// Issue/writeback wrapper around a fixed-latency fmul with credit-based issue.
// Optional flush support is enabled by defining FMUL_ISSUE_FLUSH_EN.
module fmul_issue #(
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT        = 2
) (
    input  logic        clk,
    input  logic        rstn,
    fmul_issue_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [LAT-1:0]   r_v;
    logic [TAG_W-1:0] r_t  [LAT];
    logic [31:0]      r_fy [FIFO_DEPTH];
    logic [TAG_W-1:0] r_ft [FIFO_DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_occ;

    logic             w_flush;
    logic             w_credit;
    logic             w_fire;
    logic             w_cap;
    logic             w_pop;
    logic             w_nempty;
    logic [PW+1:0]    w_cnt;

`ifdef FMUL_ISSUE_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // Credit: queued plus in-flight ops must leave a free FIFO slot.
    always_comb begin
        w_cnt    = {1'b0, r_occ} + (PW+2)'($countones(r_v));
        w_credit = (w_cnt < (PW+2)'(FIFO_DEPTH));
    end

    assign w_nempty      = (r_occ != '0);
    assign bus.req_ready = w_credit & ~w_flush;
    assign w_fire        = bus.req_valid & bus.req_ready;
    assign w_cap         = r_v[LAT-1] & ~w_flush;
    assign w_pop         = w_nempty & bus.res_ready & ~w_flush;

    assign bus.mul_x1    = w_fire ? bus.req_x1 : 32'h0;
    assign bus.mul_x2    = w_fire ? bus.req_x2 : 32'h0;

    assign bus.res_valid = w_nempty;
    assign bus.res_y     = r_fy[r_rp];
    assign bus.res_tag   = r_ft[r_rp];
    assign bus.busy      = (|r_v) | w_nempty;

    // Tag/valid shift pipe mirroring fmul's fixed latency.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_t[i] <= '0;
            end
        end else begin
            if (w_flush) begin
                r_v <= '0;
            end else begin
                r_v[0] <= w_fire;
                for (int i = 1; i < LAT; i++) begin
                    r_v[i] <= r_v[i-1];
                end
            end
            r_t[0] <= bus.req_tag;
            for (int i = 1; i < LAT; i++) begin
                r_t[i] <= r_t[i-1];
            end
        end
    end

    // Result storage: capture fmul output with its tag at the write pointer.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fy[i] <= '0;
                r_ft[i] <= '0;
            end
        end else if (w_cap) begin
            r_fy[r_wp] <= bus.mul_y;
            r_ft[r_wp] <= r_t[LAT-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo depth.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else if (w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (w_cap) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_cap, w_pop})
                2'b10:   r_occ <= r_occ + (PW+1)'(1);
                2'b01:   r_occ <= r_occ - (PW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_issue.sv
// Bench for fmul_issue: behavioural fmul, queue scoreboard, directed steps.
// Exercises FMUL_ISSUE_FLUSH_EN flush behaviour when that macro is defined.
module tb_fmul_issue;
    localparam int TW = 5;
    localparam int D  = 4;
    localparam int L  = 2;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   y;
        int            rc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   nerr = 0;
    int   nchk = 0;
    int   cyc = 0;
    int   nfire = 0;
    int   npop = 0;
    exp_t q[$];
    logic [31:0]   pop_y[$];
    logic [TW-1:0] pop_t[$];
    logic [31:0]   ops [10];
    logic [31:0]   f1 = 32'h0;
    logic [31:0]   f2 = 32'h0;

    fmul_issue_if #(.TAG_W(TW)) bus ();

    fmul_issue #(.TAG_W(TW), .FIFO_DEPTH(D), .LAT(L)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single-precision product from sign/mantissa/exponent arithmetic, RNE.
    function automatic logic [31:0] fref(input logic [31:0] a,
                                         input logic [31:0] b);
        longint unsigned ma, mb, m;
        int  ea, eb, e;
        bit  s, g, st;
        s  = a[31] ^ b[31];
        ma = (a[30:23] == 8'd0) ? longint'(a[22:0])
                                : longint'({1'b1, a[22:0]});
        mb = (b[30:23] == 8'd0) ? longint'(b[22:0])
                                : longint'({1'b1, b[22:0]});
        ea = (a[30:23] == 8'd0) ? -149 : int'(a[30:23]) - 150;
        eb = (b[30:23] == 8'd0) ? -149 : int'(b[30:23]) - 150;
        m  = ma * mb;
        e  = ea + eb;
        if (m == 0) return {s, 31'b0};
        g  = 1'b0;
        st = 1'b0;
        while (m >= (64'd1 << 24)) begin
            st = st | g; g = m[0]; m = m >> 1; e++;
        end
        while (m < (64'd1 << 23) && e > -149) begin
            m = m << 1; e--;
        end
        while (e < -149) begin
            st = st | g; g = m[0]; m = m >> 1; e++;
        end
        if (g && (st || m[0])) m = m + 1;
        if (m >= (64'd1 << 24)) begin
            m = m >> 1; e++;
        end
        if (m >= (64'd1 << 23)) return {s, 8'(e + 150), m[22:0]};
        return {s, 8'd0, m[22:0]};
    endfunction

    // Behavioural fmul: two register stages from x1/x2 to y.
    always @(posedge clk) begin
        f1 <= fref(bus.mul_x1, bus.mul_x2);
        f2 <= f1;
    end
    assign bus.mul_y = f2;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs against the model, then advance a clock.
    task automatic tick();
        bit   fire;
        bit   hv;
        exp_t e;
        #1;
        hv = (q.size() != 0) ? (q[0].rc <= cyc) : 1'b0;
        chk("req_ready", 64'(bus.req_ready), 64'(q.size() < D));
        chk("busy", 64'(bus.busy), 64'(q.size() != 0));
        chk("res_valid", 64'(bus.res_valid), 64'(hv));
        fire = bus.req_valid && bus.req_ready;
        chk("mul_x1", 64'(bus.mul_x1), 64'(fire ? bus.req_x1 : 32'h0));
        chk("mul_x2", 64'(bus.mul_x2), 64'(fire ? bus.req_x2 : 32'h0));
        if (bus.res_valid && bus.res_ready && q.size() != 0) begin
            chk("res_tag", 64'(bus.res_tag), 64'(q[0].tag));
            chk("res_y", 64'(bus.res_y), 64'(q[0].y));
            pop_y.push_back(bus.res_y);
            pop_t.push_back(bus.res_tag);
            void'(q.pop_front());
            npop++;
        end
        if (fire) begin
            e.tag = bus.req_tag;
            e.y   = fref(bus.req_x1, bus.req_x2);
            e.rc  = cyc + L + 1;
            q.push_back(e);
            nfire++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        ops[0] = 32'h00000000; ops[1] = 32'h80000000;
        ops[2] = 32'h3F800000; ops[3] = 32'h40000000;
        ops[4] = 32'h3F000000; ops[5] = 32'hC0400000;
        ops[6] = 32'h3FC00000; ops[7] = 32'h00000001;
        ops[8] = 32'h00400000; ops[9] = 32'h41200000;
        bus.req_valid = 1'b0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b0;
`ifdef FMUL_ISSUE_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        // Reset state
        #1;
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_res_y", 64'(bus.res_y), 64'(0));
        chk("rst_res_tag", 64'(bus.res_tag), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        cyc  = 0;

        // Step 1: single op 1.0 * 2.0, tag 3
        pop_y.delete(); pop_t.delete();
        bus.req_valid = 1'b1;
        bus.req_x1    = 32'h3F800000;
        bus.req_x2    = 32'h40000000;
        bus.req_tag   = 5'd3;
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (5) tick();
        chk("t1_npop", 64'(pop_y.size()), 64'(1));
        chk("t1_y", 64'(pop_y[0]), 64'(32'h40000000));
        chk("t1_tag", 64'(pop_t[0]), 64'(3));

        // Step 2: fill under backpressure, then drain in order
        pop_y.delete(); pop_t.delete();
        bus.res_ready = 1'b0;
        n0 = nfire;
        for (int i = 1; i <= 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_tag   = TW'(i);
            bus.req_x1    = ops[$urandom_range(0, 9)];
            bus.req_x2    = ops[$urandom_range(0, 9)];
            tick();
        end
        chk("t2_fired", 64'(nfire - n0), 64'(4));
        bus.req_valid = 1'b0;
        repeat (3) tick();
        bus.res_ready = 1'b1;
        repeat (6) tick();
        chk("t2_npop", 64'(pop_t.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk("t2_order", 64'(pop_t[k]), 64'(k + 1));
        end

        // Step 3: ten ops, random backpressure, zero/subnormal included
        pop_y.delete(); pop_t.delete();
        n0 = nfire;
        for (int k = 0; k < 300 && (nfire - n0) < 10; k++) begin
            bus.req_valid = 1'b1;
            bus.req_tag   = TW'(nfire - n0);
            if (nfire - n0 == 0) begin
                bus.req_x1 = 32'h00000000;
                bus.req_x2 = 32'h3F800000;
            end else if (nfire - n0 == 1) begin
                bus.req_x1 = 32'h00000001;
                bus.req_x2 = 32'h40000000;
            end else begin
                bus.req_x1 = ops[$urandom_range(0, 9)];
                bus.req_x2 = ops[$urandom_range(0, 9)];
            end
            bus.res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t3_fired", 64'(nfire - n0), 64'(10));
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) tick();
        chk("t3_left", 64'(q.size()), 64'(0));
        chk("t3_npop", 64'(pop_t.size()), 64'(10));
        chk("t3_zero", 64'(pop_y[0]), 64'(32'h00000000));
        chk("t3_subn", 64'(pop_y[1]), 64'(32'h00000002));
        for (int k = 0; k < 10; k++) begin
            chk("t3_order", 64'(pop_t[k]), 64'(k));
        end

        // Step 4: reset with two queued and two in flight
        pop_y.delete(); pop_t.delete();
        bus.res_ready = 1'b0;
        for (int i = 10; i < 12; i++) begin
            bus.req_valid = 1'b1; bus.req_tag = TW'(i);
            bus.req_x1 = ops[$urandom_range(0, 9)];
            bus.req_x2 = ops[$urandom_range(0, 9)];
            tick();
        end
        bus.req_valid = 1'b0;
        repeat (3) tick();
        for (int i = 12; i < 14; i++) begin
            bus.req_valid = 1'b1; bus.req_tag = TW'(i);
            bus.req_x1 = ops[$urandom_range(0, 9)];
            bus.req_x2 = ops[$urandom_range(0, 9)];
            tick();
        end
        bus.req_valid = 1'b0;
        chk("t4_pre_busy", 64'(bus.busy), 64'(1));
        rstn = 1'b1;
        #1;
        chk("t4_res_valid", 64'(bus.res_valid), 64'(0));
        chk("t4_busy", 64'(bus.busy), 64'(0));
        chk("t4_req_ready", 64'(bus.req_ready), 64'(1));
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        cyc++;
        bus.res_ready = 1'b1;
        repeat (6) tick();
        chk("t4_npop", 64'(pop_t.size()), 64'(0));

`ifdef FMUL_ISSUE_FLUSH_EN
        // Step 5: flush with a request present, three ops outstanding
        pop_y.delete(); pop_t.delete();
        bus.res_ready = 1'b0;
        for (int i = 20; i < 23; i++) begin
            bus.req_valid = 1'b1; bus.req_tag = TW'(i);
            bus.req_x1 = ops[$urandom_range(0, 9)];
            bus.req_x2 = ops[$urandom_range(0, 9)];
            tick();
        end
        bus.flush   = 1'b1;
        bus.req_tag = TW'(23);
        bus.req_x1  = 32'h3F800000;
        bus.req_x2  = 32'h3F800000;
        #1;
        chk("t5_req_ready", 64'(bus.req_ready), 64'(0));
        chk("t5_mul_x1", 64'(bus.mul_x1), 64'(0));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        q.delete();
        repeat (L + 3) tick();
        chk("t5_npop", 64'(pop_t.size()), 64'(0));
`endif

        // Step 6: 2*D+1 back-to-back ops, pointer wrap
        pop_y.delete(); pop_t.delete();
        bus.res_ready = 1'b1;
        n0 = nfire;
        for (int i = 0; i < 2 * D + 1; i++) begin
            bus.req_valid = 1'b1; bus.req_tag = TW'(i);
            bus.req_x1 = ops[$urandom_range(0, 9)];
            bus.req_x2 = ops[$urandom_range(0, 9)];
            tick();
            chk("t6_occ_bound", 64'(dut.r_occ <= D), 64'(1));
        end
        chk("t6_fired", 64'(nfire - n0), 64'(2 * D + 1));
        bus.req_valid = 1'b0;
        repeat (6) tick();
        chk("t6_npop", 64'(pop_t.size()), 64'(2 * D + 1));
        for (int k = 0; k < 2 * D + 1; k++) begin
            chk("t6_order", 64'(pop_t[k]), 64'(k));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
